// File: rtl/dff8_stim_src.sv
// Beat-stream source for an 8-bit clock-enabled register: paced clk_en strobes with
// incrementing or Galois-LFSR data. Define DFF8_STIM_HOLD_EN to add the hold input.
module dff8_stim_src #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 8,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [7:0]       init,
    input  logic [CNT_W-1:0] beats,
    input  logic [DIV_W-1:0] div,
`ifdef DFF8_STIM_HOLD_EN
    input  logic             hold,
`endif
    output logic             clk_en,
    output logic [7:0]       Din,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [7:0]       LfsrMask = 8'hB8;

    logic             hold_act;
    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [7:0]       value_q, value_d;
    logic [7:0]       value_nxt;
    logic             clk_en_q, clk_en_d;
    logic [7:0]       din_q, din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef DFF8_STIM_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Next pattern value; the LFSR never reaches zero from a non-zero seed.
    always_comb begin
        value_nxt = value_q + 8'd1;
        if (mode_q) begin
            value_nxt = (value_q >> 1) ^ (value_q[0] ? LfsrMask : 8'h00);
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        value_d  = value_q;
        clk_en_d = 1'b0;
        din_d    = din_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = mode;
                    div_d    = div;
                    phase_d  = div;
                    remain_d = beats;
                    value_d  = (mode && (init == 8'h00)) ? SEED : init;
                    busy_d   = 1'b1;
                    state_d  = (beats == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // stop outranks both a due strobe and hold
                if (stop) begin
                    state_d = StDone;
                end else if (!hold_act) begin
                    if (phase_q == '0) begin
                        clk_en_d = 1'b1;
                        din_d    = value_q;
                        value_d  = value_nxt;
                        phase_d  = div_q;
                        remain_d = remain_q - CntOne;
                        if (remain_q == CntOne) begin
                            state_d = StDone;
                        end
                    end else begin
                        phase_d = phase_q - DivOne;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            div_q    <= '0;
            phase_q  <= '0;
            remain_q <= '0;
            value_q  <= 8'h00;
            clk_en_q <= 1'b0;
            din_q    <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            value_q  <= value_d;
            clk_en_q <= clk_en_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign clk_en = clk_en_q;
    assign Din    = din_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_dff8_stim_src.sv
// Directed bench for dff8_stim_src: burst patterns, pacing, boundaries, reset and hold.
module tb_dff8_stim_src;

    logic       Clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] init;
    logic [7:0] beats;
    logic [7:0] div;
`ifdef DFF8_STIM_HOLD_EN
    logic       hold;
`endif
    logic       clk_en;
    logic [7:0] Din;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;

    // Per-burst observations, cycle 0 = cycle after the edge that sampled start.
    int         n_strobe;
    logic [7:0] sval [16];
    int         scyc [16];
    int         done_cyc;
    logic       busy_at_done;

    dff8_stim_src #(
        .CNT_W(8),
        .DIV_W(8),
        .SEED (8'hA5)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .init  (init),
        .beats (beats),
        .div   (div),
`ifdef DFF8_STIM_HOLD_EN
        .hold  (hold),
`endif
        .clk_en(clk_en),
        .Din   (Din),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // start_at/stop_at: cycle in which to drive a spurious start or a stop (-1 = never).
    task automatic run_burst(input logic m, input logic [7:0] ini, input logic [7:0] bts,
                             input logic [7:0] dv, input int start_at, input int stop_at);
        int cyc;
        mode  = m;
        init  = ini;
        beats = bts;
        div   = dv;
        start = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 0;
        n_strobe = 0;
        done_cyc = -1;
        check("busy_after_start", 32'(busy), 32'd1);
        while (cyc < 200) begin
            if (clk_en && n_strobe < 16) begin
                sval[n_strobe] = Din;
                scyc[n_strobe] = cyc;
                n_strobe++;
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                start        = 1'b0;
                stop         = 1'b0;
                break;
            end
            start = (cyc == start_at);
            stop  = (cyc == stop_at);
            if (start) begin
                init  = 8'd99;
                beats = 8'd1;
                div   = 8'd0;
                mode  = ~m;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("busy_low_at_done", 32'(busy_at_done), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        init  = 8'h00;
        beats = 8'h00;
        div   = 8'h00;
`ifdef DFF8_STIM_HOLD_EN
        hold  = 1'b0;
`endif
        #2;
        check("rst_clk_en", 32'(clk_en), 32'd0);
        check("rst_din", 32'(Din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Increment, div 0: four back-to-back strobes
        run_burst(1'b0, 8'd55, 8'd4, 8'd0, -1, -1);
        check("inc_n", 32'(n_strobe), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("inc_val", 32'(sval[i]), 32'(55 + i));
            check("inc_cyc", 32'(scyc[i]), 32'(1 + i));
        end
        check("inc_done_cyc", 32'(done_cyc), 32'd5);
        check("inc_din_hold", 32'(Din), 32'd58);
        step();
        check("inc_done_width", 32'(done), 32'd0);
        check("inc_din_after", 32'(Din), 32'd58);

        // Pacing and wrap
        run_burst(1'b0, 8'hFE, 8'd3, 8'd2, -1, -1);
        check("pace_n", 32'(n_strobe), 32'd3);
        check("pace_v0", 32'(sval[0]), 32'hFE);
        check("pace_v1", 32'(sval[1]), 32'hFF);
        check("pace_v2", 32'(sval[2]), 32'h00);
        check("pace_c0", 32'(scyc[0]), 32'd3);
        check("pace_c1", 32'(scyc[1]), 32'd6);
        check("pace_c2", 32'(scyc[2]), 32'd9);
        check("pace_done_cyc", 32'(done_cyc), 32'd10);

        // LFSR with init 0 substitutes the seed; started in the previous done cycle
        run_burst(1'b1, 8'h00, 8'd3, 8'd0, -1, -1);
        check("lfsr_n", 32'(n_strobe), 32'd3);
        check("lfsr_v0", 32'(sval[0]), 32'hA5);
        check("lfsr_v1", 32'(sval[1]), 32'hEA);
        check("lfsr_v2", 32'(sval[2]), 32'h75);
        check("lfsr_done_cyc", 32'(done_cyc), 32'd4);

        // Zero beats
        run_burst(1'b0, 8'd9, 8'd0, 8'd3, -1, -1);
        check("zero_n", 32'(n_strobe), 32'd0);
        check("zero_done_cyc", 32'(done_cyc), 32'd1);
        check("zero_din_kept", 32'(Din), 32'h75);

        // Spurious start during RUN with changed inputs
        run_burst(1'b0, 8'd10, 8'd3, 8'd1, 3, -1);
        check("ign_n", 32'(n_strobe), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("ign_val", 32'(sval[i]), 32'(10 + i));
            check("ign_cyc", 32'(scyc[i]), 32'(2 + 2 * i));
        end
        check("ign_done_cyc", 32'(done_cyc), 32'd7);

        // Stop sampled at the edge where the second strobe is due
        run_burst(1'b0, 8'd20, 8'd5, 8'd1, -1, 3);
        check("stop_n", 32'(n_strobe), 32'd1);
        check("stop_v0", 32'(sval[0]), 32'd20);
        check("stop_done_cyc", 32'(done_cyc), 32'd5);
        check("stop_din_hold", 32'(Din), 32'd20);
        step();

        // Asynchronous reset mid-burst
        mode  = 1'b0;
        init  = 8'd0;
        beats = 8'd10;
        div   = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_strobe", 32'(clk_en), 32'd1);
        check("mid_din", 32'(Din), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_clk_en", 32'(clk_en), 32'd0);
        check("arst_din", 32'(Din), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_no_done", 32'(done), 32'd0);
            check("arst_no_busy", 32'(busy), 32'd0);
        end
        run_burst(1'b0, 8'd7, 8'd2, 8'd0, -1, -1);
        check("post_rst_n", 32'(n_strobe), 32'd2);
        check("post_rst_v0", 32'(sval[0]), 32'd7);
        check("post_rst_v1", 32'(sval[1]), 32'd8);
        check("post_rst_done_cyc", 32'(done_cyc), 32'd3);
        step();

`ifdef DFF8_STIM_HOLD_EN
        // Hold for two cycles right after the first strobe
        mode  = 1'b0;
        init  = 8'd30;
        beats = 8'd3;
        div   = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("hold_s0", 32'(clk_en), 32'd1);
        check("hold_v0", 32'(Din), 32'd30);
        hold = 1'b1;
        step();
        check("hold_gap0", 32'(clk_en), 32'd0);
        step();
        check("hold_gap1", 32'(clk_en), 32'd0);
        hold = 1'b0;
        step();
        check("hold_s1", 32'(clk_en), 32'd1);
        check("hold_v1", 32'(Din), 32'd31);
        step();
        check("hold_s2", 32'(clk_en), 32'd1);
        check("hold_v2", 32'(Din), 32'd32);
        step();
        check("hold_done", 32'(done), 32'd1);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
